grey_step_checker: RTL

GREY_STEP_CHECKER -- requirements
Module: grey_step_checker

---
 rtl/grey_pkg.sv | 14 +
 rtl/grey2bin.sv | 21 ++
 rtl/grey_step_checker.sv | 95 +++++++++
 3 files changed

// File: rtl/grey_pkg.sv
// Shared defaults and FSM encoding for the Gray step checker.
// Imported by the checker and its bench.
package grey_pkg;

  localparam int GREY_W = 4;
  localparam int ERR_W_DEF = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

endpackage

// File: rtl/grey2bin.sv
// Combinational Gray-to-binary converter.
// Each binary bit is the XOR of all Gray bits at or above it.
module grey2bin #(
  parameter int WIDTH = grey_pkg::GREY_W
) (
  input  logic [WIDTH-1:0] grey,
  output logic [WIDTH-1:0] bin
);

  // Running XOR from the MSB down gives the prefix-XOR result.
  always_comb begin
    logic acc;
    acc = 1'b0;
    bin = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      acc    = acc ^ grey[i];
      bin[i] = acc;
    end
  end

endmodule

// File: rtl/grey_step_checker.sv
// Checks that a Gray counter only holds or steps by one.
// Flags illegal jumps with a sticky flag and saturating count.
module grey_step_checker
  import grey_pkg::*;
#(
  parameter int WIDTH = GREY_W,
  parameter int ERR_W = ERR_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] grey_i,
  output logic [WIDTH-1:0] bin_o,
  output logic             bin_valid_o,
  output logic             wrap_o,
  output logic             step_err_o,
  output logic [ERR_W-1:0] err_cnt_o
);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] ref_q;
  logic [WIDTH-1:0] conv;
  logic [WIDTH-1:0] ref_nxt;
  logic             is_hold;
  logic             is_step;
  logic             illegal;

  grey2bin #(
    .WIDTH(WIDTH)
  ) u_conv (
    .grey(grey_i),
    .bin (conv)
  );

  assign ref_nxt = ref_q + WIDTH'(1);
  assign is_hold = (conv == ref_q);
  assign is_step = (conv == ref_nxt);
  assign illegal = !is_hold && !is_step;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // Next state: clear wins over a sample; errors latch into FAULT.
  always_comb begin
    state_d = state_q;
    if (clr_i) begin
      state_d = EMPTY;
    end else if (en_i) begin
      unique case (state_q)
        EMPTY:   state_d = TRACK;
        TRACK:   state_d = illegal ? FAULT : TRACK;
        FAULT:   state_d = FAULT;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Registered outputs, reference and error bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ref_q       <= '0;
      bin_o       <= '0;
      bin_valid_o <= 1'b0;
      wrap_o      <= 1'b0;
      step_err_o  <= 1'b0;
      err_cnt_o   <= '0;
    end else if (clr_i) begin
      bin_valid_o <= 1'b0;
      wrap_o      <= 1'b0;
      step_err_o  <= 1'b0;
      err_cnt_o   <= '0;
    end else if (en_i) begin
      ref_q       <= conv;
      bin_o       <= conv;
      bin_valid_o <= 1'b1;
      wrap_o      <= 1'b0;
      if (state_q != EMPTY) begin
        wrap_o <= is_step && (ref_q == '1);
        if (illegal) begin
          step_err_o <= 1'b1;
          if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + ERR_W'(1);
        end
      end
    end else begin
      bin_valid_o <= 1'b0;
      wrap_o      <= 1'b0;
    end
  end

endmodule
